branch_flush_ctrl: RTL
======================

Name: branch_flush_ctrl

Overview:
Parametrised branch-resolution and flush sequencer at the EX stage of the 5-stage RV32I pipeline. It evaluates branch conditions from the ALU flag bits (V,C,N,Z,L), and optionally resolves JAL/JALR. On a taken control transfer it issues a registered PC redirect and holds the IF/ID flush for a configurable number of cycles. It keeps saturating branch and taken counters for performance monitoring.

Parameters:
XLEN, 32, PC/target width.
FLUSH_CYCLES, 2, cycles flush_o is held after a taken transfer; legal range 1..15.
CNT_W, 16, width of the performance counters.
JUMP_EN, 1, 1 = JAL (1101111) and JALR (1100111) are resolved here as always-taken; 0 = only opcode 1100011 is handled.

Ports:
clk  input  1  pipeline clock, rising edge.
reset  input  1  asynchronous, active-high reset.
valid_i  input  1  EX stage holds a real instruction.
stall_i  input  1  pipeline stall; freezes all state.
opcode_i  input  7  EX instruction opcode.
funct3_i  input  3  EX instruction funct3.
V, C, N, Z, L  input  1 each  ALU flags for rs1-rs2; L = unsigned less-than; C is carried for observability only.
pc_i  input  XLEN  PC of the EX instruction.
target_i  input  XLEN  computed branch/jump target.
redirect_o  output  1  one-cycle pulse: fetch loads pc_redirect_o.
pc_redirect_o  output  XLEN  registered redirect target.
pc_prev_o  output  XLEN  registered PC of the last resolved transfer.
flush_o  output  1  kill IF/ID contents.
busy_o  output  1  FSM not in IDLE.
illegal_o  output  1  one-cycle pulse: branch opcode with funct3 010 or 011.
branch_cnt_o  output  CNT_W  resolved transfers, saturating.
taken_cnt_o  output  CNT_W  taken transfers, saturating.

Behaviour:
- Reset (async): all outputs are 0, the counters are 0, and the FSM is in IDLE. Reset asserted mid-flush aborts the flush immediately.
- Condition on funct3 for opcode 1100011:
  - 000 BEQ: Z
  - 001 BNE: !Z
  - 100 BLT: N^V
  - 101 BGE: !(N^V)
  - 110 BLTU: L
  - 111 BGEU: !L
  - 010 and 011: not taken, illegal_o pulses, and no counter increments.
- Resolve event: valid_i & !stall_i & state==IDLE & (branch opcode | (JUMP_EN & jump opcode)).
- FSM states: IDLE and FLUSH, with a 4-bit down-counter fcnt.
- IDLE, resolve taken at edge T:
  - next cycle: redirect_o=1, pc_redirect_o=target_i, pc_prev_o=pc_i, flush_o=1.
  - fcnt loads FLUSH_CYCLES-1 and the state goes to FLUSH.
  - branch_cnt and taken_cnt each add 1.
- IDLE, resolve not taken: pc_prev_o=pc_i and branch_cnt adds 1. No redirect and no flush.
- FLUSH:
  - redirect_o=0 after the first cycle; flush_o=1 and busy_o=1.
  - fcnt decrements each non-stalled cycle.
  - When fcnt==0 with !stall_i, flush_o drops on the next edge and the state returns to IDLE.
- Latency: flush_o is high for exactly FLUSH_CYCLES non-stalled cycles, starting the cycle after resolution.
- valid_i is ignored in FLUSH because the EX content there is wrong-path.
- A branch can be resolved in the cycle the FSM re-enters IDLE.
- stall_i=1 behaviour:
  - No resolution. fcnt, the state and the counters hold; flush_o holds its value.
  - redirect_o is still a strict single pulse. It is never repeated or stretched by a stall.
- If stall_i rises in the same cycle as a resolve candidate, the candidate is not resolved. It is resolved on the first non-stalled cycle.
- Counters saturate at all ones. taken_cnt never exceeds branch_cnt.
- JAL/JALR with JUMP_EN=1 are always taken, regardless of flags and funct3. With JUMP_EN=0 they are ignored entirely.
- No arithmetic on PC: the target comes from target_i; pc_prev_o is a plain register.

Decomposition:
- Package branch_pkg holds:
  - opcode constants OP_BRANCH, OP_JAL, OP_JALR.
  - funct3 constants F3_BEQ through F3_BGEU.
  - FSM state encoding S_IDLE and S_FLUSH.
- Sub-module branch_cond_eval: combinational, inputs funct3 and flags, outputs taken and illegal. It is instantiated once in branch_flush_ctrl.

Test Plan:
- BEQ with Z=1, pc_i=0x100, target_i=0x140, FLUSH_CYCLES=2 -> redirect_o pulses for 1 cycle with pc_redirect_o=0x140; flush_o is high for 2 cycles; pc_prev_o=0x100; branch_cnt=1, taken_cnt=1.
- Sweep all six funct3 codes with flag patterns (N=1,V=0), (N=1,V=1), (L=1), (Z=0) -> taken matches the condition table; not-taken cases give no redirect and branch_cnt increments only.
- Taken BNE, then stall_i=1 for 3 cycles in the second flush cycle -> flush_o stays high through the stall, totalling 2 non-stalled cycles; redirect_o pulses only once.
- funct3=010 with opcode 1100011 -> illegal_o pulses once; no redirect; counters unchanged.
- JALR with JUMP_EN=1 -> redirect regardless of flags. Same stimulus with JUMP_EN=0 -> no response.
- Reset asserted mid-flush -> flush_o, busy_o and the counters go to 0 asynchronously. Preload branch_cnt to 0xFFFF with CNT_W=16 -> it stays 0xFFFF after another branch.

Source files
------------

// File: rtl/branch_pkg.sv
// Shared encodings for the EX-stage branch resolution and flush sequencer.
package branch_pkg;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_FLUSH = 1'b1
    } state_t;

endpackage

// File: rtl/branch_flush_ctrl_if.sv
// EX-stage branch bus: instruction/flag inputs and redirect/flush/monitor outputs.
interface branch_flush_ctrl_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 16
);
    logic             valid_i;
    logic             stall_i;
    logic [6:0]       opcode_i;
    logic [2:0]       funct3_i;
    logic             V;
    logic             C;
    logic             N;
    logic             Z;
    logic             L;
    logic [XLEN-1:0]  pc_i;
    logic [XLEN-1:0]  target_i;
    logic             redirect_o;
    logic [XLEN-1:0]  pc_redirect_o;
    logic [XLEN-1:0]  pc_prev_o;
    logic             flush_o;
    logic             busy_o;
    logic             illegal_o;
    logic [CNT_W-1:0] branch_cnt_o;
    logic [CNT_W-1:0] taken_cnt_o;

    modport master (
        output valid_i, stall_i, opcode_i, funct3_i, V, C, N, Z, L, pc_i, target_i,
        input  redirect_o, pc_redirect_o, pc_prev_o, flush_o, busy_o, illegal_o,
        input  branch_cnt_o, taken_cnt_o
    );

    modport slave (
        input  valid_i, stall_i, opcode_i, funct3_i, V, C, N, Z, L, pc_i, target_i,
        output redirect_o, pc_redirect_o, pc_prev_o, flush_o, busy_o, illegal_o,
        output branch_cnt_o, taken_cnt_o
    );
endinterface

// File: rtl/branch_cond_eval.sv
// Combinational RV32I branch condition evaluation from ALU flags of rs1-rs2.
module branch_cond_eval
    import branch_pkg::*;
(
    input  logic [2:0] i_funct3,
    input  logic       i_v,
    input  logic       i_n,
    input  logic       i_z,
    input  logic       i_l,
    output logic       o_taken,
    output logic       o_illegal
);

    always_comb begin
        o_taken   = 1'b0;
        o_illegal = 1'b0;
        case (i_funct3)
            F3_BEQ:  o_taken = i_z;
            F3_BNE:  o_taken = ~i_z;
            F3_BLT:  o_taken = i_n ^ i_v;
            F3_BGE:  o_taken = ~(i_n ^ i_v);
            F3_BLTU: o_taken = i_l;
            F3_BGEU: o_taken = ~i_l;
            default: o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/branch_flush_ctrl.sv
// Resolves branches/jumps at EX, issues a registered PC redirect and holds IF/ID flush.
module branch_flush_ctrl
    import branch_pkg::*;
#(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned CNT_W        = 16,
    parameter bit          JUMP_EN      = 1'b1
) (
    input logic                clk,
    input logic                reset,
    branch_flush_ctrl_if.slave bus
);

    localparam logic [3:0] FCNT_INIT = 4'(FLUSH_CYCLES - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [3:0]       r_fcnt;
    logic [3:0]       w_fcnt_nxt;
    logic             r_redirect;
    logic             r_illegal;
    logic [XLEN-1:0]  r_pc_redirect;
    logic [XLEN-1:0]  r_pc_prev;
    logic [CNT_W-1:0] r_branch_cnt;
    logic [CNT_W-1:0] r_taken_cnt;

    logic w_cond_taken;
    logic w_cond_illegal;
    logic w_is_branch;
    logic w_is_jump;
    logic w_cand;
    logic w_illegal;
    logic w_resolve;
    logic w_taken;

    branch_cond_eval u_cond (
        .i_funct3  (bus.funct3_i),
        .i_v       (bus.V),
        .i_n       (bus.N),
        .i_z       (bus.Z),
        .i_l       (bus.L),
        .o_taken   (w_cond_taken),
        .o_illegal (w_cond_illegal)
    );

    assign w_is_branch = (bus.opcode_i == OP_BRANCH);
    assign w_is_jump   = JUMP_EN && ((bus.opcode_i == OP_JAL) || (bus.opcode_i == OP_JALR));
    // Wrong-path instructions during FLUSH and stalled ones never resolve.
    assign w_cand      = bus.valid_i && !bus.stall_i && (r_state == S_IDLE);
    assign w_illegal   = w_cand && w_is_branch && w_cond_illegal;
    assign w_resolve   = w_cand && ((w_is_branch && !w_cond_illegal) || w_is_jump);
    assign w_taken     = w_resolve && (w_is_jump || w_cond_taken);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_fcnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_fcnt  <= w_fcnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_fcnt_nxt  = r_fcnt;
        case (r_state)
            S_IDLE: begin
                if (w_taken) begin
                    w_state_nxt = S_FLUSH;
                    w_fcnt_nxt  = FCNT_INIT;
                end
            end
            S_FLUSH: begin
                if (!bus.stall_i) begin
                    if (r_fcnt == 4'd0) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_fcnt_nxt = r_fcnt - 4'd1;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        bus.flush_o = (r_state == S_FLUSH);
        bus.busy_o  = (r_state != S_IDLE);
    end

    // Redirect and illegal are recomputed every cycle, so a stall cannot stretch them.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_redirect    <= 1'b0;
            r_illegal     <= 1'b0;
            r_pc_redirect <= '0;
            r_pc_prev     <= '0;
            r_branch_cnt  <= '0;
            r_taken_cnt   <= '0;
        end else begin
            r_redirect <= w_taken;
            r_illegal  <= w_illegal;
            if (w_taken) begin
                r_pc_redirect <= bus.target_i;
            end
            if (w_resolve) begin
                r_pc_prev <= bus.pc_i;
                if (r_branch_cnt != '1) begin
                    r_branch_cnt <= r_branch_cnt + 1'b1;
                end
            end
            if (w_taken && (r_taken_cnt != '1)) begin
                r_taken_cnt <= r_taken_cnt + 1'b1;
            end
        end
    end

    assign bus.redirect_o    = r_redirect;
    assign bus.illegal_o     = r_illegal;
    assign bus.pc_redirect_o = r_pc_redirect;
    assign bus.pc_prev_o     = r_pc_prev;
    assign bus.branch_cnt_o  = r_branch_cnt;
    assign bus.taken_cnt_o   = r_taken_cnt;

endmodule
